// File: rtl/ucsbece154a_instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: descriptor kind and
// ALU codes, opcode constants, funct3/funct7 values and the descriptor struct.
package ucsbece154a_instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_LW    = 3'd0,
    KIND_SW    = 3'd1,
    KIND_RTYPE = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_IALU  = 3'd4,
    KIND_JAL   = 3'd5,
    KIND_LUI   = 3'd6
  } kind_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_e;

  // Opcodes, matching what the main decoder expects
  localparam logic [6:0] instr_lw_op    = 7'b0000011;
  localparam logic [6:0] instr_sw_op    = 7'b0100011;
  localparam logic [6:0] instr_rtype_op = 7'b0110011;
  localparam logic [6:0] instr_beq_op   = 7'b1100011;
  localparam logic [6:0] instr_itype_op = 7'b0010011;
  localparam logic [6:0] instr_jal_op   = 7'b1101111;
  localparam logic [6:0] instr_lui_op   = 7'b0110111;

  localparam logic [2:0] f3_add  = 3'b000;
  localparam logic [2:0] f3_slt  = 3'b010;
  localparam logic [2:0] f3_or   = 3'b110;
  localparam logic [2:0] f3_and  = 3'b111;
  localparam logic [2:0] f3_lwsw = 3'b010;
  localparam logic [2:0] f3_beq  = 3'b000;

  localparam logic [6:0] f7_sub = 7'b0100000;
  localparam logic [6:0] f7_def = 7'b0000000;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  // funct3 for an ALU selector; caller has already rejected codes >= 5
  function automatic logic [2:0] alu_f3(input logic [2:0] alu);
    case (alu)
      ALU_SLT: alu_f3 = f3_slt;
      ALU_OR:  alu_f3 = f3_or;
      ALU_AND: alu_f3 = f3_and;
      default: alu_f3 = f3_add;
    endcase
  endfunction

endpackage

// File: rtl/ucsbece154a_instr_encoder_encode_word.sv
// Combinational descriptor-to-machine-word encoder.
// Optional macro UCSBECE154A_IMM_CHECK_EN adds immediate range checking;
// without it immediates are truncated to their fields.
module ucsbece154a_encode_word
  import ucsbece154a_instr_encoder_pkg::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        illegal
);

  logic [31:0] imm;
  logic        imm_bad;
  logic        unused_imm;

  assign imm        = desc.imm;
  assign unused_imm = ^imm;

`ifdef UCSBECE154A_IMM_CHECK_EN
  logic signed [31:0] simm;
  assign simm = $signed(imm);

  // Range check against the field each format can hold
  always_comb begin
    imm_bad = 1'b0;
    case (desc.kind)
      KIND_LW, KIND_SW, KIND_IALU:
        imm_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      KIND_BEQ:
        imm_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      KIND_JAL:
        imm_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      KIND_LUI:
        imm_bad = (imm[11:0] != 12'd0);
      default: imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  // Build the word per format and flag illegal kind/alu combinations
  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (desc.kind)
      KIND_LW:
        word = {imm[11:0], desc.rs1, f3_lwsw, desc.rd, instr_lw_op};
      KIND_SW:
        word = {imm[11:5], desc.rs2, desc.rs1, f3_lwsw, imm[4:0], instr_sw_op};
      KIND_RTYPE: begin
        illegal = (desc.alu > ALU_SLT);
        word = {(desc.alu == ALU_SUB) ? f7_sub : f7_def, desc.rs2, desc.rs1,
                alu_f3(desc.alu), desc.rd, instr_rtype_op};
      end
      KIND_IALU: begin
        illegal = (desc.alu > ALU_SLT) || (desc.alu == ALU_SUB);
        word = {imm[11:0], desc.rs1, alu_f3(desc.alu), desc.rd, instr_itype_op};
      end
      KIND_BEQ:
        word = {imm[12], imm[10:5], desc.rs2, desc.rs1, f3_beq,
                imm[4:1], imm[11], instr_beq_op};
      KIND_JAL:
        word = {imm[20], imm[10:1], imm[11], imm[19:12], desc.rd, instr_jal_op};
      KIND_LUI:
        word = {imm[31:12], desc.rd, instr_lui_op};
      default: illegal = 1'b1;
    endcase
    if (imm_bad) illegal = 1'b1;
  end

endmodule

// File: rtl/ucsbece154a_instr_encoder.sv
// Streams encoded RV32I words into instruction memory, one descriptor per
// cycle while loading. Optional macro UCSBECE154A_IMM_CHECK_EN (in the
// encoder) rejects out-of-range immediates.
module ucsbece154a_instr_encoder
  import ucsbece154a_instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64,
  localparam int         CW        = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          last_i,
  input  logic [2:0]    kind_i,
  input  logic [2:0]    alu_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic [31:0]   imm_i,
  output logic          we_o,
  output logic [31:0]   waddr_o,
  output logic [31:0]   wdata_o,
  output logic [CW-1:0] count_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e      state;
  desc_t       desc;
  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic [CW-1:0] count_nxt;

  assign desc      = '{kind: kind_i, alu: alu_i, rd: rd_i, rs1: rs1_i,
                       rs2: rs2_i, imm: imm_i};
  assign accept    = valid_i && (state == LOAD);
  assign count_nxt = count_o + CW'(1);
  assign ready_o   = (state == LOAD);
  assign done_o    = (state == DONE);

  ucsbece154a_encode_word u_enc (
    .desc    (desc),
    .word    (word),
    .illegal (illegal)
  );

  // FSM, word counter and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_o    <= 1'b0;
      waddr_o <= BASE_ADDR;
      wdata_o <= 32'd0;
      count_o <= '0;
      err_o   <= 1'b0;
    end else begin
      we_o <= 1'b0;
      case (state)
        IDLE, DONE: if (start_i) begin
          state   <= LOAD;
          count_o <= '0;
          err_o   <= 1'b0;
        end
        LOAD: if (accept) begin
          if (illegal) begin
            err_o <= 1'b1;
            if (last_i) state <= DONE;
          end else begin
            we_o    <= 1'b1;
            waddr_o <= BASE_ADDR + (32'(count_o) << 2);
            wdata_o <= word;
            count_o <= count_nxt;
            if (last_i || (count_nxt == CW'(DEPTH))) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ucsbece154a_instr_encoder.md
# ucsbece154a_instr_encoder

Sequential RV32I instruction encoder that turns structured instruction descriptors into 32-bit machine words and streams them into instruction memory. It is the producing end of the instruction path: it emits exactly the opcode, funct3 and funct7 bit patterns that the main and ALU decoders consume. It supports the same subset: lw, sw, R-type add/sub/and/or/slt, I-type ALU, beq, jal and lui. It sits between a testbench or boot-loader source and the imem write port.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.
- DEPTH, 64: maximum number of words per program; must be ≥1.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  begin a new program. Honoured in IDLE and DONE only.
- valid_i  input  1  descriptor valid.
- ready_o  output  1  descriptor accepted when valid_i && ready_o.
- last_i  input  1  accepted descriptor is the final one of the program.
- kind_i  input  3  0=LW, 1=SW, 2=RTYPE, 3=BEQ, 4=IALU, 5=JAL, 6=LUI; 7 is illegal.
- alu_i  input  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT. Used by RTYPE and IALU only.
- rd_i, rs1_i, rs2_i  input  5 each  register fields.
- imm_i  input  32  signed byte offset or immediate. For LUI it is the full upper value.
- we_o  output  1  imem write strobe.
- waddr_o  output  32  write byte address.
- wdata_o  output  32  encoded instruction.
- count_o  output  $clog2(DEPTH+1)  number of words written in the current program.
- done_o  output  1  program complete.
- err_o  output  1  sticky; a descriptor was rejected.

## Operation
- FSM has three states: IDLE, LOAD, DONE.
  - ready_o = (state == LOAD).
  - done_o = (state == DONE).
- IDLE/DONE + start_i → LOAD. On that edge, count and err_o clear.
- In LOAD, an accepted legal descriptor registers one write. last_i or count reaching DEPTH after that write → DONE.
- Encoding:
  - lw: imm[11:0] rs1 010 rd 0000011
  - sw: imm[11:5] rs2 rs1 010 imm[4:0] 0100011
  - R-type: f7 rs2 rs1 f3 rd 0110011. f7 = 0100000 for SUB, else 0000000.
  - I-ALU: imm[11:0] rs1 f3 rd 0010011
  - beq: imm[12|10:5] rs2 rs1 000 imm[4:1|11] 1100011
  - jal: imm[20|10:1|11|19:12] rd 1101111
  - lui: imm[31:12] rd 0110111
  - f3 values: ADD/SUB=000, SLT=010, OR=110, AND=111.
- Illegal descriptors: kind 7, alu ≥5, or SUB with IALU.
  - No write is made. err_o sets. count does not advance.
  - last_i on an illegal beat still moves the FSM to DONE.
- Unused descriptor fields are ignored.

## Timing
- Reset values: state IDLE; ready_o 0, we_o 0, waddr_o BASE_ADDR, wdata_o 0, count_o 0, done_o 0, err_o 0.
- Latency: a beat accepted at edge N produces we_o=1 for exactly one cycle after edge N.
  - waddr_o = BASE_ADDR + 4·(count before the write).
  - count_o increments at the same edge.
- Throughput: one descriptor per cycle in LOAD.
- The final beat is accepted in the same cycle the FSM leaves LOAD. ready_o is 0 from the next cycle. done_o and the final we_o pulse are high in the same cycle.
- Full: the DEPTH-th write forces DONE regardless of last_i. No address wraps.
- start_i in LOAD is ignored.
- start_i and valid_i high in the same cycle in IDLE: no beat is accepted.
- Reset mid-program: the pending write is cancelled (we_o low next cycle) and the program is abandoned.

## Configuration
- Macro: UCSBECE154A_IMM_CHECK_EN.
- With the macro defined, immediate ranges are checked. An out-of-range immediate is illegal (no write, err_o set). Ranges:
  - I/S: −2048..2047.
  - B: −4096..4094, even.
  - J: −2^20..2^20−2, even.
  - LUI: imm[11:0] must be 0.
- Without the macro, immediates are silently truncated to their fields and low bits are dropped. Only kind/alu legality is checked.

## Structure
- The shared defines header holds:
  - kind and alu codes;
  - opcode values (reusing the existing instr_*_op constants);
  - funct3/funct7 constants.
- One combinational sub-module, ucsbece154a_encode_word, takes the descriptor and returns word and illegal. The top module holds the FSM, counter and output registers.

## Test plan
- IALU ADD rd=1, rs1=0, imm=5 → wdata 0x00500093 at waddr BASE_ADDR, one cycle after the handshake.
- RTYPE ADD then SUB, rd=3, rs1=1, rs2=2 → 0x002081B3 and 0x402081B3 on back-to-back cycles; count_o = 2.
- LW rd=2, rs1=1, imm=8 → 0x0080A103. SW rs2=2, rs1=1, imm=12 → 0x0020A623.
- BEQ rs1=1, rs2=2, imm=−8 → 0xFE208CE3. JAL rd=1, imm=16 → 0x010000EF. LUI rd=5, imm=0x12345000 → 0x123452B7 with last_i → done_o high, ready_o low next cycle.
- DEPTH=2, three valid beats → two writes, DONE, third beat not accepted. Then start_i → count_o 0 and writes restart at BASE_ADDR.
- IALU SUB, then IALU imm=4096 (macro on) → no writes, err_o = 1. With the macro off, the second beat writes imm field 0x000.
